bt_alu_sequencer: RTL and testbench

- Multi-cycle balanced-ternary arithmetic controller for the calculator datapath.
- Accepts one operation at a time over a valid/ready request port, then sequences a single trit-serial full-adder slice (sum/carry) across N-trit operands.
- Performs ADD, SUB and NEG directly; MUL is a shift-and-add built on the same slice.
- Returns results over a valid/ready response port with overflow and error flags, so wide arithmetic reuses one adder cell instead of a full-width array.

---
 rtl/bt_alu_if.sv | 33 +++
 rtl/bt_alu_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_bt_alu_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bt_alu_if.sv
// rtl/bt_alu_if.sv - request/response bundle for the balanced-ternary ALU sequencer
//
// Ports:
//   req_valid/req_ready/req_op/req_a/req_b : operation request (2 bits per trit)
//   rsp_valid/rsp_ready/rsp_result         : result response
//   rsp_overflow/rsp_error                 : response flags
//   busy                                   : sequencer not idle
// Modports: master = requester/consumer side, slave = sequencer side.
interface bt_alu_if #(
    parameter int N = 4
);
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_result;
    logic           rsp_overflow;
    logic           rsp_error;
    logic           busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_error, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_error, busy
    );
endinterface

// File: rtl/bt_alu_sequencer.sv
// rtl/bt_alu_sequencer.sv - trit-serial balanced-ternary ADD/SUB/MUL/NEG sequencer
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bt_alu_if.slave (request, response, flags, busy)
// Trit codes: 01 = -1, 11 = 0, 10 = +1, 00 = invalid.
// One full-adder slice is reused for every trit; MUL is shift-and-add over it.
module bt_alu_sequencer #(
    parameter int N = 4
) (
    input  logic    clk,
    input  logic    rst,
    bt_alu_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(2 * N + 1);

    localparam logic [1:0] T_ZERO = 2'b11;
    localparam logic [1:0] T_POS  = 2'b10;
    localparam logic [1:0] T_NEG  = 2'b01;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_MUL,
        S_NEG,
        S_RESP
    } state_t;

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [2*W-1:0]  prod_r;
    logic [1:0]      carry_r;
    logic [CW-1:0]   tidx;
    logic [CW-1:0]   row;
    logic            req_ready_r;
    logic            busy_r;
    logic            rsp_valid_r;
    logic [W-1:0]    result_r;
    logic            ovf_r;
    logic            err_r;

    function automatic logic signed [3:0] t2i(input logic [1:0] t);
        case (t)
            T_NEG:   return -4'sd1;
            T_POS:   return 4'sd1;
            default: return 4'sd0;
        endcase
    endfunction

    function automatic logic [1:0] i2t(input logic signed [3:0] v);
        if (v > 4'sd0)
            return T_POS;
        else if (v < 4'sd0)
            return T_NEG;
        else
            return T_ZERO;
    endfunction

    function automatic logic [W-1:0] neg_all(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++)
            r[2*i +: 2] = {v[2*i], v[2*i+1]};
        return r;
    endfunction

    function automatic logic has_invalid(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N; i++)
            if (v[2*i +: 2] == 2'b00)
                bad = 1'b1;
        return bad;
    endfunction

    // Shared slice: x + y + carry_r -> sum_t, cout_t
    logic [1:0]       x_t, y_t, b_row, a_trit, sum_t, cout_t;
    logic signed [3:0] s;
    logic [CW-1:0]    ka;
    logic             ovf_mul;

    always_comb begin
        x_t    = T_ZERO;
        y_t    = T_ZERO;
        ka     = (tidx < CW'(N)) ? tidx : '0;
        a_trit = a_r[2*ka +: 2];
        b_row  = b_r[2*row +: 2];
        if (state == S_ADD) begin
            x_t = a_trit;
            y_t = b_r[2*ka +: 2];
        end else if (state == S_MUL) begin
            // Partial-product trit: A, -A or 0 depending on multiplier trit of this row
            if (b_row == T_POS)
                x_t = a_trit;
            else if (b_row == T_NEG)
                x_t = {a_trit[0], a_trit[1]};
            y_t = prod_r[2*(row + tidx) +: 2];
        end
        s = t2i(x_t) + t2i(y_t) + t2i(carry_r);
        if (s > 4'sd1) begin
            sum_t  = i2t(s - 4'sd3);
            cout_t = T_POS;
        end else if (s < -4'sd1) begin
            sum_t  = i2t(s + 4'sd3);
            cout_t = T_NEG;
        end else begin
            sum_t  = i2t(s);
            cout_t = T_ZERO;
        end
        // Evaluated on the final MUL cycle, whose carry lands in the top trit
        ovf_mul = (carry_r != T_ZERO);
        for (int i = N; i < 2*N - 1; i++)
            if (prod_r[2*i +: 2] != T_ZERO)
                ovf_mul = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            a_r         <= {N{T_ZERO}};
            b_r         <= {N{T_ZERO}};
            prod_r      <= {W{T_ZERO}};
            carry_r     <= T_ZERO;
            tidx        <= '0;
            row         <= '0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            result_r    <= {N{T_ZERO}};
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        a_r         <= bus.req_a;
                        b_r         <= (bus.req_op == OP_SUB) ? neg_all(bus.req_b) : bus.req_b;
                        prod_r      <= {W{T_ZERO}};
                        carry_r     <= T_ZERO;
                        tidx        <= '0;
                        row         <= '0;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        ovf_r       <= 1'b0;
                        err_r       <= 1'b0;
                        if (has_invalid(bus.req_a) ||
                            (bus.req_op != OP_NEG && has_invalid(bus.req_b))) begin
                            state       <= S_RESP;
                            rsp_valid_r <= 1'b1;
                            err_r       <= 1'b1;
                            result_r    <= {N{T_ZERO}};
                        end else begin
                            case (bus.req_op)
                                OP_ADD, OP_SUB: state <= S_ADD;
                                OP_MUL:         state <= S_MUL;
                                default:        state <= S_NEG;
                            endcase
                        end
                    end
                end
                S_ADD: begin
                    result_r[2*ka +: 2] <= sum_t;
                    carry_r             <= cout_t;
                    if (tidx == CW'(N - 1)) begin
                        state       <= S_RESP;
                        rsp_valid_r <= 1'b1;
                        ovf_r       <= (cout_t != T_ZERO);
                    end else begin
                        tidx <= tidx + 1'b1;
                    end
                end
                S_MUL: begin
                    if (tidx < CW'(N)) begin
                        prod_r[2*(row + tidx) +: 2] <= sum_t;
                        carry_r                     <= cout_t;
                        tidx                        <= tidx + 1'b1;
                    end else begin
                        // Row carry goes into trit row+N, untouched by earlier rows
                        prod_r[2*(row + CW'(N)) +: 2] <= carry_r;
                        carry_r                       <= T_ZERO;
                        tidx                          <= '0;
                        if (row == CW'(N - 1)) begin
                            state       <= S_RESP;
                            rsp_valid_r <= 1'b1;
                            result_r    <= prod_r[W-1:0];
                            ovf_r       <= ovf_mul;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                S_NEG: begin
                    result_r    <= neg_all(a_r);
                    state       <= S_RESP;
                    rsp_valid_r <= 1'b1;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_r;
    assign bus.busy         = busy_r;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_result   = result_r;
    assign bus.rsp_overflow = ovf_r;
    assign bus.rsp_error    = err_r;
endmodule

// File: tb/tb_bt_alu_sequencer.sv
// tb/tb_bt_alu_sequencer.sv - self-checking bench for bt_alu_sequencer
module tb_bt_alu_sequencer;
    localparam int N = 4;
    localparam int W = 2 * N;
    localparam int M = 3 ** N;
    localparam int H = (M - 1) / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bt_alu_if #(.N(N)) bus();
    bt_alu_sequencer #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_pending = 1'b0;
    int exp_res, exp_ovf, exp_err;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] enc(input int v);
        logic [W-1:0] r;
        int x, m;
        x = v;
        for (int i = 0; i < N; i++) begin
            m = ((x % 3) + 3) % 3;
            if (m == 1) begin
                r[2*i +: 2] = 2'b10;
                x = (x - 1) / 3;
            end else if (m == 2) begin
                r[2*i +: 2] = 2'b01;
                x = (x + 1) / 3;
            end else begin
                r[2*i +: 2] = 2'b11;
                x = x / 3;
            end
        end
        return r;
    endfunction

    function automatic int dec(input logic [W-1:0] t);
        int v, p;
        v = 0;
        p = 1;
        for (int i = 0; i < N; i++) begin
            case (t[2*i +: 2])
                2'b10:   v += p;
                2'b01:   v -= p;
                2'b11:   ;
                default: return 9999;
            endcase
            p *= 3;
        end
        return v;
    endfunction

    function automatic bit has_inv(input logic [W-1:0] t);
        for (int i = 0; i < N; i++)
            if (t[2*i +: 2] == 2'b00)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int wrap(input int t);
        return ((t + H) % M + M) % M - H;
    endfunction

    // Every cycle: busy/ready consistency, and full response check whenever rsp_valid
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_vs_not_ready", int'(bus.busy), int'(!bus.req_ready));
            if (bus.rsp_valid) begin
                if (exp_pending) begin
                    check("result", dec(bus.rsp_result), exp_res);
                    check("overflow", int'(bus.rsp_overflow), exp_ovf);
                    check("error", int'(bus.rsp_error), exp_err);
                    check("req_ready_in_resp", int'(bus.req_ready), 0);
                end else begin
                    check("unexpected_rsp_valid", int'(bus.rsp_valid), 0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        logic [W-1:0] zero_t;
        zero_t = {N{2'b11}};
        check({tag, "_req_ready"}, int'(bus.req_ready), 1);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        check({tag, "_overflow"}, int'(bus.rsp_overflow), 0);
        check({tag, "_error"}, int'(bus.rsp_error), 0);
        check({tag, "_result_bits"}, int'(bus.rsp_result), int'(zero_t));
    endtask

    task automatic run_op(input string tag, input int op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int er, input int eo,
                          input int ee, input int el, input int hold);
        int lat, guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'(op);
        bus.req_a     = a;
        bus.req_b     = b;
        guard = 0;
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check({tag, "_accept_timeout"}, int'(bus.req_ready), 1);
            bus.req_valid = 1'b0;
            return;
        end
        exp_res = er;
        exp_ovf = eo;
        exp_err = ee;
        exp_pending = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs while busy: the latched operands must be unaffected
        bus.req_a     = W'($urandom);
        bus.req_b     = W'($urandom);
        bus.req_op    = 2'($urandom);
        bus.req_valid = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, el);
        bus.req_valid = 1'b0;
        repeat (hold) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        exp_pending = 1'b0;
        @(negedge clk);
        check({tag, "_rsp_valid_after_hs"}, int'(bus.rsp_valid), 0);
        check({tag, "_req_ready_after_hs"}, int'(bus.req_ready), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, eb;
        int op, av, bv, t, er, eo, ee, el, ti;
        bit bad;

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        run_op("add_13_1", 0, enc(13), enc(1), 14, 0, 0, 5, 0);
        run_op("add_20_25", 0, enc(20), enc(25), -36, 1, 0, 5, 1);
        run_op("sub_0_40", 1, enc(0), enc(40), -40, 0, 0, 5, 0);
        run_op("mul_5_m8", 2, enc(5), enc(-8), -40, 0, 0, 21, 0);
        run_op("mul_7_m6", 2, enc(7), enc(-6), 39, 1, 0, 21, 2);
        run_op("neg_27", 3, enc(27), enc(0), -27, 0, 0, 2, 0);
        eb = enc(5);
        eb[5:4] = 2'b00;
        run_op("add_bad_b", 0, enc(3), eb, 0, 0, 1, 1, 0);
        run_op("add_3_4_bp", 0, enc(3), enc(4), 7, 0, 0, 5, 5);

        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 3));
            av = int'($urandom_range(0, 2 * H)) - H;
            bv = int'($urandom_range(0, 2 * H)) - H;
            a = enc(av);
            b = enc(bv);
            if ($urandom_range(0, 7) == 0) begin
                ti = int'($urandom_range(0, N - 1));
                if ($urandom_range(0, 1) == 0) a[2*ti +: 2] = 2'b00;
                else b[2*ti +: 2] = 2'b00;
            end
            bad = has_inv(a) || (op != 3 && has_inv(b));
            case (op)
                0: t = av + bv;
                1: t = av - bv;
                2: t = av * bv;
                default: t = -av;
            endcase
            if (bad) begin
                er = 0; eo = 0; ee = 1; el = 1;
            end else begin
                er = wrap(t);
                eo = (t > H || t < -H) ? 1 : 0;
                ee = 0;
                el = (op < 2) ? N + 1 : (op == 2) ? N * (N + 1) + 1 : 2;
            end
            run_op("rand", op, a, b, er, eo, ee, el, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        bus.req_a     = enc(13);
        bus.req_b     = enc(-11);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mul_busy_before_reset", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_mul_rst");
        @(negedge clk);
        rst = 1'b0;
        run_op("add_1_1_after_rst", 0, enc(1), enc(1), 2, 0, 0, 5, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
